// File: rtl/sprite_rom_pkg.sv
// Shared types and default sizing for the sprite ROM arbiter.
package sprite_rom_pkg;

  localparam int N_REQ     = 4;
  localparam int ROM_LAT   = 2;
  localparam int MAX_BURST = 16;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic {ARB, BURST} arb_state_t;

endpackage

// File: rtl/sprite_rom_rr_pick.sv
// Rotate-priority picker: first asserted request at or after ptr, wrapping at N_REQ.
module sprite_rom_rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);
  import sprite_rom_pkg::*;

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      // explicit wrap keeps non-power-of-2 requester counts correct
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin ROM arbiter with burst locking and latency-matched rvalid tags.
// Define SPRITE_ROM_ARB_FIXED_PRIO_EN to pin the pointer at 0 (fixed priority).
module sprite_rom_arbiter #(
  parameter int N_REQ     = sprite_rom_pkg::N_REQ,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 12,
  parameter int ROM_LAT   = sprite_rom_pkg::ROM_LAT,
  parameter int MAX_BURST = sprite_rom_pkg::MAX_BURST
) (
  input  logic                          clk40MHz,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0]              lock,
  input  logic [N_REQ-1:0][ADDR_W-1:0]  addr,
  output logic [N_REQ-1:0]              gnt,
  output logic [DATA_W-1:0]             rdata,
  output logic [N_REQ-1:0]              rvalid,
  output logic                          rom_en,
  output logic [ADDR_W-1:0]             rom_addr,
  input  logic [DATA_W-1:0]             rom_data
);
  import sprite_rom_pkg::*;

  localparam int PTR_W  = $clog2(N_REQ);
  localparam int BCNT_W = $clog2(MAX_BURST + 1);

  arb_state_t          state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [PTR_W-1:0]    gnt_idx;

  logic [N_REQ-1:0]    pick_gnt;
  logic [PTR_W-1:0]    pick_idx;
  logic                pick_any;

  // stage 0 lines up with rom_en, stage ROM_LAT with rom_data
  logic [ROM_LAT:0][N_REQ-1:0] vld_pipe;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] i);
`ifdef SPRITE_ROM_ARB_FIXED_PRIO_EN
    return (i == i) ? '0 : '0;
`else
    return (i == PTR_W'(N_REQ - 1)) ? '0 : i + PTR_W'(1);
`endif
  endfunction

  sprite_rom_rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    bcnt_d  = bcnt_q;
    gnt     = '0;
    gnt_idx = pick_idx;
    case (state_q)
      ARB: begin
        if (pick_any) begin
          gnt = pick_gnt;
          if (lock[pick_idx]) begin
            state_d = BURST;
            owner_d = pick_idx;
            bcnt_d  = BCNT_W'(1);
          end else begin
            ptr_d = next_ptr(pick_idx);
          end
        end
      end
      BURST: begin
        gnt_idx = owner_q;
        if (req[owner_q]) begin
          gnt[owner_q] = 1'b1;
          bcnt_d       = bcnt_q + BCNT_W'(1);
          if (!lock[owner_q] || (bcnt_q + BCNT_W'(1)) == BCNT_W'(MAX_BURST)) begin
            state_d = ARB;
            ptr_d   = next_ptr(owner_q);
            bcnt_d  = '0;
          end
        end else begin
          // owner let go: spend one bubble, then hand the pointer on
          state_d = ARB;
          ptr_d   = next_ptr(owner_q);
          bcnt_d  = '0;
        end
      end
      default: state_d = ARB;
    endcase
    if (rst) gnt = '0;
  end

  always_ff @(posedge clk40MHz) begin
    if (rst) begin
      state_q  <= ARB;
      ptr_q    <= '0;
      owner_q  <= '0;
      bcnt_q   <= '0;
      rom_addr <= '0;
      vld_pipe <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      bcnt_q      <= bcnt_d;
      vld_pipe[0] <= gnt;
      for (int k = 1; k <= ROM_LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
      if (|gnt) rom_addr <= addr[gnt_idx];
    end
  end

  assign rom_en = |vld_pipe[0];
  assign rvalid = vld_pipe[ROM_LAT];
  assign rdata  = rom_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Randomized scoreboard bench for sprite_rom_arbiter with a spec-level arbitration model.
module tb_sprite_rom_arbiter;
  import sprite_rom_pkg::*;

  localparam int NR = 4;
  localparam int AW = 12;
  localparam int DW = 12;
  localparam int MB = 16;

  logic                   clk40MHz;
  logic                   rst;
  logic [NR-1:0]          req, lock, gnt, rvalid;
  logic [NR-1:0][AW-1:0]  addr;
  logic [DW-1:0]          rdata, rom_data;
  logic                   rom_en;
  logic [AW-1:0]          rom_addr;

  sprite_rom_arbiter dut (
    .clk40MHz (clk40MHz),
    .rst      (rst),
    .req      (req),
    .lock     (lock),
    .addr     (addr),
    .gnt      (gnt),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  initial clk40MHz = 1'b0;
  always #5 clk40MHz = ~clk40MHz;

  // ROM model: two-cycle read latency from sampled rom_en
  rgb444_t       rom_mem [4096];
  logic [DW-1:0] rp0 = '0, rp1 = '0;
  always @(posedge clk40MHz) begin
    if (rom_en) rp0 <= rom_mem[rom_addr];
    rp1 <= rp0;
  end
  assign rom_data = rp1;

  typedef struct {
    int      id;
    rgb444_t data;
  } exp_t;

  exp_t          q[$];
  exp_t          mon_e;
  int            checks = 0;
  int            errors = 0;
  int            m_ptr = 0, m_owner = -1, m_cnt = 0;
  logic [AW-1:0] addr_r [NR];
  logic [NR-1:0] pend = '0;

  always @(negedge clk40MHz) begin
    if (rvalid !== '0) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexpected got rvalid=%b rdata=%h, none expected", rvalid, rdata);
      end else begin
        mon_e = q.pop_front();
        if (rvalid !== NR'(1 << mon_e.id) || rdata !== mon_e.data) begin
          errors++;
          $display("FAIL rvalid_data got rvalid=%b rdata=%h, want id=%0d rdata=%h",
                   rvalid, rdata, mon_e.id, mon_e.data);
        end
      end
    end
  end

  function automatic int nxt(input int x);
`ifdef SPRITE_ROM_ARB_FIXED_PRIO_EN
    return (x < 0) ? 0 : 0;
`else
    return (x + 1) % NR;
`endif
  endfunction

  // Reference: returns the requester that should win this cycle, -1 for none
  function automatic int model_pick(input logic [NR-1:0] rq, input logic [NR-1:0] lk);
    int w = -1;
    if (m_owner >= 0) begin
      if (rq[m_owner]) begin
        w = m_owner;
        m_cnt++;
        if (!lk[w] || m_cnt == MB) begin
          m_owner = -1;
          m_ptr   = nxt(w);
        end
      end else begin
        m_ptr   = nxt(m_owner);
        m_owner = -1;
      end
    end else begin
      for (int k = 0; k < NR; k++)
        if (w < 0 && rq[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
      if (w >= 0) begin
        if (lk[w]) begin
          m_owner = w;
          m_cnt   = 1;
        end else begin
          m_ptr = nxt(w);
        end
      end
    end
    return w;
  endfunction

  task automatic step(input logic [NR-1:0] rq, input logic [NR-1:0] lk,
                      input bit use_c, input logic [NR-1:0] c_exp, input string nm);
    int            w;
    logic [NR-1:0] exp_oh;
    exp_t          e;
    req  = rq;
    lock = lk;
    for (int i = 0; i < NR; i++) addr[i] = addr_r[i];
    @(negedge clk40MHz);
    w      = model_pick(rq, lk);
    exp_oh = '0;
    if (w >= 0) exp_oh[w] = 1'b1;
    checks++;
    if (gnt !== exp_oh) begin
      errors++;
      $display("FAIL gnt_model %s got %b want %b (req %b lock %b)", nm, gnt, exp_oh, rq, lk);
    end
    if (use_c) begin
      checks++;
      if (gnt !== c_exp) begin
        errors++;
        $display("FAIL gnt_%s got %b want %b", nm, gnt, c_exp);
      end
    end
    if (w >= 0) begin
      e.id   = w;
      e.data = rom_mem[addr_r[w]];
      q.push_back(e);
      addr_r[w] = AW'($urandom);
      pend[w]   = 1'b0;
    end
    @(posedge clk40MHz); #1;
  endtask

  task automatic do_reset(input int n);
    rst  = 1'b1;
    req  = '1;
    lock = '0;
    q.delete();
    @(posedge clk40MHz); #1;
    repeat (n) begin
      @(negedge clk40MHz);
      checks += 3;
      if (gnt !== '0) begin
        errors++;
        $display("FAIL reset_gnt got %b want 0", gnt);
      end
      if (rom_en !== 1'b0) begin
        errors++;
        $display("FAIL reset_rom_en got %b want 0", rom_en);
      end
      if (rvalid !== '0) begin
        errors++;
        $display("FAIL reset_rvalid got %b want 0", rvalid);
      end
      @(posedge clk40MHz); #1;
    end
    rst     = 1'b0;
    req     = '0;
    m_ptr   = 0;
    m_owner = -1;
    m_cnt   = 0;
    pend    = '0;
  endtask

  task automatic idle_rv_check();
    req = '0;
    @(negedge clk40MHz);
    checks++;
    if (rvalid !== '0 || gnt !== '0) begin
      errors++;
      $display("FAIL dropped_read got rvalid=%b gnt=%b want 0", rvalid, gnt);
    end
    @(posedge clk40MHz); #1;
  endtask

  initial begin
    logic [NR-1:0] lk;
    for (int i = 0; i < 4096; i++) rom_mem[i] = rgb444_t'(DW'($urandom));
    for (int i = 0; i < NR; i++) addr_r[i] = AW'($urandom);
    for (int i = 0; i < NR; i++) addr[i] = '0;
    req  = '1;
    lock = '0;

    do_reset(2);

`ifdef SPRITE_ROM_ARB_FIXED_PRIO_EN
    repeat (8) step(4'b1010, 4'b0000, 1, 4'b0010, "fixed_prio");
`else
    for (int k = 0; k < 8; k++) step(4'b1111, 4'b0000, 1, NR'(1 << (k % NR)), "round_robin");
    step(4'b0100, 4'b0100, 1, 4'b0100, "burst");
    for (int k = 1; k < 16; k++) step(4'b1111, 4'b0100, 1, 4'b0100, "burst");
    step(4'b1111, 4'b0100, 1, 4'b1000, "burst_end");
    repeat (3) step(4'b1111, 4'b0100, 0, '0, "burst_tail");
    step(4'b0000, 4'b0000, 1, 4'b0000, "burst_release");
    repeat (5) step(4'b0110, 4'b0010, 1, 4'b0010, "owner_lock");
    step(4'b0100, 4'b0000, 1, 4'b0000, "owner_bubble");
    step(4'b0100, 4'b0000, 1, 4'b0100, "owner_next");
`endif

    // reset with one read in flight
    repeat (4) step('0, '0, 1, '0, "idle");
    step(4'b0001, 4'b0000, 1, 4'b0001, "midflight_gnt");
    do_reset(1);
    repeat (5) idle_rv_check();

    repeat (1500) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 45) pend[i] = 1'b1;
        lk[i] = ($urandom_range(0, 99) < 30);
      end
      step(pend, lk, 0, '0, "random");
    end

    repeat (6) step('0, '0, 0, '0, "drain");
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending reads want 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
